// File: rtl/muldiv_iterativo.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit, one bit per cycle, registered write-back triple.
// Define MULDIV_DIV_EN to build the restoring divider; without it DIVU/REMU complete in one cycle with din=0.
module muldiv_iterativo #(
    parameter int unsigned BITS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            we,
    output logic [4:0]      rw,
    output logic [BITS-1:0] din
);

    localparam int unsigned CW = $clog2(BITS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sel_hi_q, sel_hi_d;
    logic [4:0]          rd_q, rd_d;
    logic [2*BITS-1:0]   acc_q, acc_d;
    logic [BITS-1:0]     opnd_q, opnd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [4:0]          rw_q, rw_d;
    logic [BITS-1:0]     din_q, din_d;

    logic [BITS:0]       mul_sum;
    logic [2*BITS-1:0]   mul_next;
    logic [2*BITS-1:0]   step;

`ifdef MULDIV_DIV_EN
    logic                is_div_q, is_div_d;
    logic [BITS:0]       rem_sh;
    logic [BITS+1:0]     div_diff;
    logic [2*BITS-1:0]   div_next;
`endif

    // Multiply: acc = {partial product, remaining multiplier bits}; carry kept in mul_sum[BITS].
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*BITS-1:BITS]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[BITS-1:1]};
    end

`ifdef MULDIV_DIV_EN
    // Divide: acc = {remainder, dividend/quotient}; the shifted remainder needs BITS+1 bits.
    always_comb begin
        rem_sh   = acc_q[2*BITS-1:BITS-1];
        div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
        if (div_diff[BITS+1])
            div_next = {rem_sh[BITS-1:0], acc_q[BITS-2:0], 1'b0};
        else
            div_next = {div_diff[BITS-1:0], acc_q[BITS-2:0], 1'b1};
        step = is_div_q ? div_next : mul_next;
    end
`else
    always_comb begin
        step = mul_next;
    end
`endif

    always_comb begin
        state_d  = state_q;
        sel_hi_d = sel_hi_q;
        rd_d     = rd_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        rw_d     = rw_q;
        din_d    = din_q;
`ifdef MULDIV_DIV_EN
        is_div_d = is_div_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    sel_hi_d = op[0];
                    rd_d     = rd;
                    cnt_d    = '0;
                    if (op[1]) begin
`ifdef MULDIV_DIV_EN
                        is_div_d = 1'b1;
                        if (b == '0) begin
                            state_d = DONE;
                            we_d    = 1'b1;
                            rw_d    = rd;
                            din_d   = op[0] ? a : '1;
                        end else begin
                            acc_d   = {{BITS{1'b0}}, a};
                            opnd_d  = b;
                            state_d = CALC;
                        end
`else
                        state_d = DONE;
                        we_d    = 1'b1;
                        rw_d    = rd;
                        din_d   = '0;
`endif
                    end else begin
`ifdef MULDIV_DIV_EN
                        is_div_d = 1'b0;
`endif
                        acc_d   = {{BITS{1'b0}}, b};
                        opnd_d  = a;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BITS - 1)) begin
                        state_d = DONE;
                        we_d    = 1'b1;
                        rw_d    = rd_q;
                        din_d   = sel_hi_q ? step[2*BITS-1:BITS] : step[BITS-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_hi_q <= 1'b0;
            rd_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            rw_q     <= '0;
            din_q    <= '0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_hi_q <= sel_hi_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            rw_q     <= rw_d;
            din_q    <= din_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign we   = we_q;
    assign rw   = rw_q;
    assign din  = din_q;

endmodule

// File: tb/tb_muldiv_iterativo.sv
// Directed bench for muldiv_iterativo: vector table plus kill, start-while-busy and async reset sequences.
module tb_muldiv_iterativo;

    localparam int unsigned BITS = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [4:0]  rd = '0;
    logic        busy;
    logic        we;
    logic [4:0]  rw;
    logic [63:0] din;

    muldiv_iterativo #(.BITS(BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .kill  (kill),
        .op    (op),
        .a     (a),
        .b     (b),
        .rd    (rd),
        .busy  (busy),
        .we    (we),
        .rw    (rw),
        .din   (din)
    );

    always #5 clk = ~clk;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] din;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                                input logic [4:0] r, input logic [63:0] d, input int l);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.rd = r; v.din = d; v.lat = l;
        return v;
    endfunction

    // Issue one op from IDLE and check result, rw, latency, single pulse and busy release.
    task automatic run_op(input vec_t v, input string name);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 1'b0;
        @(negedge clk);
        check({name, " idle"}, {63'b0, busy}, 64'd0);
        op = v.op; a = v.a; b = v.b; rd = v.rd; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 200 && !seen; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                a = ~v.a;
                b = ~v.b;
            end
            if (we) begin
                seen = 1'b1;
                lat  = n;
                check({name, " din"}, din, v.din);
                check({name, " rw"}, {59'b0, rw}, {59'b0, v.rd});
            end
        end
        check({name, " latency"}, 64'(lat), 64'(v.lat));
        @(negedge clk);
        check({name, " busy after"}, {63'b0, busy}, 64'd0);
        check({name, " single pulse"}, {63'b0, we}, 64'd0);
    endtask

    initial begin
        int     pulses;
        int     busy_cnt;
        vec_t   rv;
        logic [1:0] rst_op;

        tbl.push_back(mk(2'b00, 64'd7, 64'd6, 5'd5, 64'h2A, 65));
        tbl.push_back(mk(2'b01, ONES, ONES, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65));
        tbl.push_back(mk(2'b00, ONES, ONES, 5'd3, 64'h1, 65));
        tbl.push_back(mk(2'b00, 64'd2, 64'd2, 5'd0, 64'd4, 65));
`ifdef MULDIV_DIV_EN
        tbl.push_back(mk(2'b10, 64'd100, 64'd7, 5'd8, 64'd14, 65));
        tbl.push_back(mk(2'b11, 64'd100, 64'd7, 5'd8, 64'd2, 65));
        tbl.push_back(mk(2'b10, 64'd123, 64'd0, 5'd9, ONES, 1));
        tbl.push_back(mk(2'b11, 64'd123, 64'd0, 5'd9, 64'd123, 1));
        tbl.push_back(mk(2'b10, ONES, 64'h1_0000_0000, 5'd10, 64'hFFFF_FFFF, 65));
        tbl.push_back(mk(2'b11, ONES, 64'h1_0000_0000, 5'd10, 64'hFFFF_FFFF, 65));
        tbl.push_back(mk(2'b10, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 5'd11, 64'd1, 65));
        tbl.push_back(mk(2'b11, 64'd5, 64'd9, 5'd11, 64'd5, 65));
`else
        tbl.push_back(mk(2'b10, 64'd100, 64'd7, 5'd8, 64'd0, 1));
        tbl.push_back(mk(2'b11, 64'd100, 64'd7, 5'd8, 64'd0, 1));
        tbl.push_back(mk(2'b10, 64'd123, 64'd0, 5'd9, 64'd0, 1));
        tbl.push_back(mk(2'b11, 64'd123, 64'd0, 5'd9, 64'd0, 1));
`endif
        tbl.push_back(mk(2'b01, 64'h8000_0000_0000_0000, 64'd4, 5'd12, 64'd2, 65));

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy", {63'b0, busy}, 64'd0);
        check("rst we", {63'b0, we}, 64'd0);
        check("rst din", din, 64'd0);
        check("rst rw", {59'b0, rw}, 64'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Kill mid-MUL at cycle 30; a start raised while busy must be ignored.
        pulses = 0;
        @(negedge clk);
        op = 2'b00; a = 64'd9; b = 64'd9; rd = 5'd7; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n < 30; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 10) begin
                start = 1'b1; rd = 5'd9; op = 2'b01;
            end
            if (we) pulses++;
        end
        @(negedge clk);
        check("kill busy before", {63'b0, busy}, 64'd1);
        kill = 1'b1;
        start = 1'b0;
        @(negedge clk);
        kill = 1'b0;
        check("kill busy drop", {63'b0, busy}, 64'd0);
        busy_cnt = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (we) pulses++;
            if (busy) busy_cnt++;
        end
        check("kill no we", 64'(pulses), 64'd0);
        check("kill stays idle", 64'(busy_cnt), 64'd0);

        // kill and start together in IDLE: nothing accepted
        @(negedge clk);
        op = 2'b00; a = 64'd1; b = 64'd1; rd = 5'd1; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill+start busy", {63'b0, busy}, 64'd0);
        pulses = 0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (we) pulses++;
        end
        check("kill+start no we", 64'(pulses), 64'd0);

        // Async reset at cycle 40 of an in-flight op
`ifdef MULDIV_DIV_EN
        rst_op = 2'b10;
`else
        rst_op = 2'b00;
`endif
        @(negedge clk);
        op = rst_op; a = 64'd100; b = 64'd7; rd = 5'd6; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n < 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        @(negedge clk);
        check("pre-reset busy", {63'b0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", {63'b0, busy}, 64'd0);
        check("async rst we", {63'b0, we}, 64'd0);
        check("async rst din", din, 64'd0);
        check("async rst rw", {59'b0, rw}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rv = mk(2'b00, 64'd3, 64'd5, 5'd4, 64'd15, 65);
        run_op(rv, "post-reset mul");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
